pwm_engine_ms: RTL

- Next-generation, parametrised transducer PWM engine for NCH channels of width W.
- Per-channel configuration is written through an addressed write port, not wide parallel arrays.
- A single time-shared preconditioner computes rise/fall edges for all channels, one channel per clock.
- Each channel has its own period counter. New edges take effect glitch-free at that channel's period wrap. Two alignment modes are supported: leading-edge and centred.

---
 rtl/pwm_engine_ms_if.sv | 30 +++
 rtl/pwm_engine_ms.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pwm_engine_ms_if.sv
// Configuration, control and status bundle for pwm_engine_ms.
interface pwm_engine_ms_if #(
    parameter int unsigned W   = 13,
    parameter int unsigned NCH = 249
);
    localparam int unsigned AW = $clog2(NCH);

    logic               SYNC;
    logic               WR_EN;
    logic [AW-1:0]      WR_ADDR;
    logic [W-1:0]       WR_CYCLE;
    logic [W-1:0]       WR_DUTY;
    logic [W-1:0]       WR_PHASE;
    logic               WR_MODE;
    logic               UPDATE;
    logic               BUSY;
    logic               DONE;
    logic [W*NCH-1:0]   TIME_CNT;
    logic [NCH-1:0]     PWM_OUT;

    modport master (
        output SYNC, WR_EN, WR_ADDR, WR_CYCLE, WR_DUTY, WR_PHASE, WR_MODE, UPDATE,
        input  BUSY, DONE, TIME_CNT, PWM_OUT
    );

    modport slave (
        input  SYNC, WR_EN, WR_ADDR, WR_CYCLE, WR_DUTY, WR_PHASE, WR_MODE, UPDATE,
        output BUSY, DONE, TIME_CNT, PWM_OUT
    );
endinterface

// File: rtl/pwm_engine_ms.sv
// Multi-channel PWM engine: addressed staging writes, one shared edge preconditioner,
// per-channel period counters with glitch-free commit at each channel's wrap.
module pwm_engine_ms #(
    parameter int unsigned W   = 13,
    parameter int unsigned NCH = 249
) (
    input  logic            CLK,
    input  logic            RST_N,
    pwm_engine_ms_if.slave  bus
);
    localparam int unsigned AW       = $clog2(NCH);
    localparam logic [AW:0]   NCH_A    = (AW+1)'(NCH);
    localparam logic [AW-1:0] LAST_IDX = AW'(NCH-1);

    typedef struct packed {
        logic [W-1:0] cycle;
        logic [W-1:0] duty;
        logic [W-1:0] phase;
        logic         mode;
    } cfg_t;

    typedef struct packed {
        logic [W-1:0] cycle;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         full_on;
        logic         full_off;
    } edge_t;

    typedef enum logic [1:0] {IDLE, CALC, FLUSH} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   idx, idx_nxt;
    logic            busy_q, done_q, busy_d, done_d;

    cfg_t            staging [NCH];
    edge_t           pending [NCH];
    edge_t           active  [NCH];
    logic [W-1:0]    cnt     [NCH];
    logic [NCH-1:0]  commit;
    logic [NCH-1:0]  wrap;
    logic [NCH-1:0]  pwm_c, pwm_q;
    logic [W*NCH-1:0] time_cnt;

    edge_t           edge_c, calc_res;
    logic [AW-1:0]   res_idx;
    logic            res_vld;
    cfg_t            e_cfg;
    logic [W:0]      e_cyc, e_ph, e_dty, e_lo, e_hi, e_r, e_f;

    // Shared preconditioner: edges of staging[idx], modulo cycle by one add/subtract
    always_comb begin
        e_cfg = staging[idx];
        e_cyc = {1'b0, e_cfg.cycle};
        e_dty = {1'b0, e_cfg.duty};
        e_ph  = {1'b0, e_cfg.phase};
        if (e_ph >= e_cyc) e_ph = e_ph - e_cyc;
        e_lo  = e_cfg.mode ? (e_dty >> 1) : '0;
        e_hi  = e_dty - e_lo;
        e_r   = (e_ph >= e_lo) ? (e_ph - e_lo) : (e_ph + e_cyc - e_lo);
        e_f   = e_ph + e_hi;
        if (e_f >= e_cyc) e_f = e_f - e_cyc;
        edge_c.cycle    = e_cfg.cycle;
        edge_c.rise     = W'(e_r);
        edge_c.fall     = W'(e_f);
        edge_c.full_on  = (e_cfg.duty >= e_cfg.cycle);
        edge_c.full_off = (e_cfg.duty == '0);
    end

    // FSM state register; BUSY/DONE are registered from the next state
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state  <= IDLE;
            idx    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE:  if (bus.UPDATE) begin
                       state_nxt = CALC;
                       idx_nxt   = '0;
                   end
            CALC:  if (idx == LAST_IDX) state_nxt = FLUSH;
                   else                 idx_nxt   = idx + AW'(1);
            FLUSH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_d = (state_nxt != IDLE);
        done_d = (state_nxt == FLUSH);
    end

    // Result stage: one CALC cycle behind, so FLUSH drains the last channel
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            res_vld  <= 1'b0;
            res_idx  <= '0;
            calc_res <= '0;
        end else begin
            res_vld  <= (state == CALC);
            res_idx  <= idx;
            calc_res <= edge_c;
        end
    end

    always_comb begin
        wrap     = '0;
        pwm_c    = '0;
        time_cnt = '0;
        for (int i = 0; i < NCH; i++) begin
            wrap[i] = (active[i].cycle <= W'(1)) || (cnt[i] == active[i].cycle - W'(1));
            time_cnt[i*W +: W] = cnt[i];
            if (active[i].full_on)
                pwm_c[i] = 1'b1;
            else if (active[i].full_off)
                pwm_c[i] = 1'b0;
            else if (active[i].rise < active[i].fall)
                pwm_c[i] = (cnt[i] >= active[i].rise) && (cnt[i] < active[i].fall);
            else if (active[i].rise > active[i].fall)
                pwm_c[i] = (cnt[i] >= active[i].rise) || (cnt[i] < active[i].fall);
            else
                pwm_c[i] = 1'b0;
        end
    end

    // Staging, pending, commit, counters and outputs
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            commit <= '0;
            pwm_q  <= '0;
            for (int i = 0; i < NCH; i++) begin
                staging[i] <= '0;
                pending[i] <= '0;
                active[i]  <= '0;
                cnt[i]     <= '0;
            end
        end else begin
            if (bus.WR_EN && !busy_q && ({1'b0, bus.WR_ADDR} < NCH_A))
                staging[bus.WR_ADDR] <= {bus.WR_CYCLE, bus.WR_DUTY, bus.WR_PHASE, bus.WR_MODE};
            if (res_vld)
                pending[res_idx] <= calc_res;
            // A fresh DONE re-arms every channel even if it commits on this same edge
            commit <= done_q ? '1 : (commit & ~wrap);
            pwm_q  <= pwm_c;
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= (bus.SYNC || wrap[i]) ? '0 : cnt[i] + W'(1);
                if (commit[i] && wrap[i])
                    active[i] <= pending[i];
            end
        end
    end

    assign bus.BUSY     = busy_q;
    assign bus.DONE     = done_q;
    assign bus.PWM_OUT  = pwm_q;
    assign bus.TIME_CNT = time_cnt;
endmodule
